mem_write_checker: RTL and testbench

Synthesizable, parametrised store-sequence checker for the MIPS processor bench and on-FPGA self-test. It monitors the data-memory write port (`memwrite`, `dataadr`, `writedata`) and matches the stores against an ordered list of N_EXP expected (address, data) pairs. Stores to a set of "don't-care" addresses are ignored. It reports pass, fail with cause, or timeout as sticky registered flags. It generalises the single-store success check to multiple ordered stores, multiple ignore addresses, a strict/lenient mode and a cycle-budget watchdog.

---
 rtl/mem_write_checker.sv | 155 +++++++++++++++
 tb/tb_mem_write_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Watches the data-memory write port of the core. It checks the stores
//   against an ordered list of expected (address, data) pairs and reports
//   pass, fail with a cause code, or timeout as sticky registered flags.
//   Stores that hit any ignore address are never counted. When STRICT = 0,
//   any other non-expected store is skipped as well.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pulse: clear all results and enter RUN
//   memwrite     store strobe from the core
//   dataadr      store address
//   writedata    store data
//   exp_addr     N_EXP packed expected addresses, entry k at [k*WIDTH +: WIDTH]
//   exp_data     N_EXP packed expected data, same packing
//   ign_addr     N_IGN packed ignore addresses, same packing
//   busy         high while in RUN
//   done         high in PASS or FAIL
//   pass / fail  terminal result flags
//   fail_code    0 none, 1 data mismatch, 2 unexpected address, 3 timeout
//   match_count  expected stores matched so far
//   err_addr/err_data  the store that caused a failure (0 on timeout)
//   cycle_count  RUN cycles elapsed, frozen once terminal
module mem_write_checker #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned N_EXP   = 4,
   parameter int unsigned N_IGN   = 2,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned STRICT  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         memwrite,
   input  logic [WIDTH-1:0]             dataadr,
   input  logic [WIDTH-1:0]             writedata,
   input  logic [N_EXP*WIDTH-1:0]       exp_addr,
   input  logic [N_EXP*WIDTH-1:0]       exp_data,
   input  logic [N_IGN*WIDTH-1:0]       ign_addr,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic                         fail,
   output logic [1:0]                   fail_code,
   output logic [$clog2(N_EXP+1)-1:0]   match_count,
   output logic [WIDTH-1:0]             err_addr,
   output logic [WIDTH-1:0]             err_data,
   output logic [$clog2(TIMEOUT+1)-1:0] cycle_count
);

   localparam int unsigned MCW = $clog2(N_EXP+1);
   localparam int unsigned CCW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
   state_t state;

   logic [WIDTH-1:0] cur_addr;
   logic [WIDTH-1:0] cur_data;
   logic             ign_hit;
   logic             addr_hit;
   logic             data_hit;
   logic             last_match;
   logic             timeout_hit;

   // Only the entry selected by match_count takes part in the compare.
   // A store to a later entry is treated as a non-expected store.
   always_comb begin
      cur_addr = '0;
      cur_data = '0;
      for (int unsigned k = 0; k < N_EXP; k++) begin
         if (match_count == MCW'(k)) begin
            cur_addr = exp_addr[k*WIDTH +: WIDTH];
            cur_data = exp_data[k*WIDTH +: WIDTH];
         end
      end
      ign_hit = 1'b0;
      for (int unsigned k = 0; k < N_IGN; k++) begin
         if (dataadr == ign_addr[k*WIDTH +: WIDTH]) ign_hit = 1'b1;
      end
   end

   assign addr_hit    = (dataadr == cur_addr);
   assign data_hit    = (writedata == cur_data);
   assign last_match  = (match_count == MCW'(N_EXP-1));
   assign timeout_hit = (cycle_count == CCW'(TIMEOUT-1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= 2'd0;
         match_count <= '0;
         err_addr    <= '0;
         err_data    <= '0;
         cycle_count <= '0;
      end else if (start) begin
         // A restart wins over a store sampled on the same edge.
         state       <= S_RUN;
         busy        <= 1'b1;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= 2'd0;
         match_count <= '0;
         err_addr    <= '0;
         err_data    <= '0;
         cycle_count <= '0;
      end else if (state == S_RUN) begin
         cycle_count <= cycle_count + 1'b1;
         // A store event on the final budget edge takes priority over the timeout.
         if (memwrite && addr_hit && data_hit) begin
            match_count <= match_count + 1'b1;
            if (last_match) begin
               state <= S_PASS;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= 1'b1;
            end else if (timeout_hit) begin
               state     <= S_FAIL;
               busy      <= 1'b0;
               done      <= 1'b1;
               fail      <= 1'b1;
               fail_code <= 2'd3;
            end
         end else if (memwrite && addr_hit) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd1;
            err_addr  <= dataadr;
            err_data  <= writedata;
         end else if (memwrite && !ign_hit && (STRICT != 0)) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd2;
            err_addr  <= dataadr;
            err_data  <= writedata;
         end else if (timeout_hit) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd3;
         end
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// Testbench for mem_write_checker. It uses three instances that share the store port:
//   A: N_EXP=1, exp (84,7), ign {80}, STRICT=1, TIMEOUT=16
//   B: same list, STRICT=0
//   C: N_EXP=3, exp (0,1),(4,2),(8,3), ign {80}, STRICT=0, TIMEOUT=16
module tb_mem_write_checker;

   logic        clk;
   logic        reset;
   logic        start_v [3];
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic [31:0]  exp_addr_1;
   logic [31:0]  exp_data_1;
   logic [95:0]  exp_addr_3;
   logic [95:0]  exp_data_3;
   logic [63:0]  ign_2;

   logic        busy_v [3];
   logic        done_v [3];
   logic        pass_v [3];
   logic        fail_v [3];
   logic [1:0]  code_v [3];
   logic [31:0] ea_v   [3];
   logic [31:0] ed_v   [3];
   logic [4:0]  cc_v   [3];
   logic        mc_a;
   logic        mc_b;
   logic [1:0]  mc_c;
   logic [1:0]  mc_v   [3];

   int checks;
   int failures;

   assign exp_addr_1 = 32'd84;
   assign exp_data_1 = 32'd7;
   assign exp_addr_3 = {32'd8, 32'd4, 32'd0};
   assign exp_data_3 = {32'd3, 32'd2, 32'd1};
   assign ign_2      = {32'd80, 32'd80};

   always_comb begin
      mc_v[0] = {1'b0, mc_a};
      mc_v[1] = {1'b0, mc_b};
      mc_v[2] = mc_c;
   end

   mem_write_checker #(.WIDTH(32), .N_EXP(1), .N_IGN(2), .TIMEOUT(16), .STRICT(1)) dut_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata),
      .exp_addr(exp_addr_1), .exp_data(exp_data_1), .ign_addr(ign_2),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
      .fail_code(code_v[0]), .match_count(mc_a), .err_addr(ea_v[0]),
      .err_data(ed_v[0]), .cycle_count(cc_v[0]));

   mem_write_checker #(.WIDTH(32), .N_EXP(1), .N_IGN(2), .TIMEOUT(16), .STRICT(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata),
      .exp_addr(exp_addr_1), .exp_data(exp_data_1), .ign_addr(ign_2),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
      .fail_code(code_v[1]), .match_count(mc_b), .err_addr(ea_v[1]),
      .err_data(ed_v[1]), .cycle_count(cc_v[1]));

   mem_write_checker #(.WIDTH(32), .N_EXP(3), .N_IGN(2), .TIMEOUT(16), .STRICT(0)) dut_c (
      .clk(clk), .reset(reset), .start(start_v[2]), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata),
      .exp_addr(exp_addr_3), .exp_data(exp_data_3), .ign_addr(ign_2),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]),
      .fail_code(code_v[2]), .match_count(mc_c), .err_addr(ea_v[2]),
      .err_data(ed_v[2]), .cycle_count(cc_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic        st;
      logic        mw;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        busy, done, pass, fail;
      logic [1:0]  code, mc;
      logic [31:0] ea, ed;
   } vec_t;

   typedef struct {
      int          idx;
      int          sel;
      logic        busy, done, pass, fail;
      logic [1:0]  code, mc;
      logic [31:0] ea, ed;
   } exp_t;

   vec_t tbl [19];
   exp_t sb [$];

   function automatic vec_t mk(int sel, logic st, logic mw, logic [31:0] adr, logic [31:0] dat,
                               logic b, logic d, logic p, logic f,
                               logic [1:0] code, logic [1:0] mc, logic [31:0] ea, logic [31:0] ed);
      vec_t v;
      v.sel = sel; v.st = st; v.mw = mw; v.adr = adr; v.dat = dat;
      v.busy = b; v.done = d; v.pass = p; v.fail = f;
      v.code = code; v.mc = mc; v.ea = ea; v.ed = ed;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic cmp_exp(exp_t e);
      string p;
      p = $sformatf("vec%0d", e.idx);
      chk({p, " busy"}, 64'(busy_v[e.sel]), 64'(e.busy));
      chk({p, " done"}, 64'(done_v[e.sel]), 64'(e.done));
      chk({p, " pass"}, 64'(pass_v[e.sel]), 64'(e.pass));
      chk({p, " fail"}, 64'(fail_v[e.sel]), 64'(e.fail));
      chk({p, " fail_code"}, 64'(code_v[e.sel]), 64'(e.code));
      chk({p, " match_count"}, 64'(mc_v[e.sel]), 64'(e.mc));
      chk({p, " err_addr"}, 64'(ea_v[e.sel]), 64'(e.ea));
      chk({p, " err_data"}, 64'(ed_v[e.sel]), 64'(e.ed));
   endtask

   task automatic pulse_start(int sel);
      @(negedge clk);
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
   endtask

   task automatic store(logic [31:0] a, logic [31:0] d);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      #1;
      @(negedge clk);
      memwrite = 1'b0;
   endtask

   initial begin
      exp_t e;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      memwrite = 1'b0;
      dataadr  = '0;
      writedata = '0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

      //         sel st mw adr  dat  busy done pass fail code mc  ea  ed
      tbl[0]  = mk(0, 1, 0,  0,  0,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[1]  = mk(0, 0, 1, 80,  5,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[2]  = mk(0, 0, 1, 84,  7,   0,  1,   1,   0,   0,  1,  0,  0);
      tbl[3]  = mk(0, 1, 0,  0,  0,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[4]  = mk(0, 0, 1, 84,  6,   0,  1,   0,   1,   1,  0, 84,  6);
      tbl[5]  = mk(0, 1, 0,  0,  0,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[6]  = mk(0, 0, 1, 96,  1,   0,  1,   0,   1,   2,  0, 96,  1);
      tbl[7]  = mk(0, 0, 1, 84,  7,   0,  1,   0,   1,   2,  0, 96,  1);
      tbl[8]  = mk(1, 1, 0,  0,  0,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[9]  = mk(1, 0, 1, 96,  1,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[10] = mk(1, 0, 1, 84,  7,   0,  1,   1,   0,   0,  1,  0,  0);
      tbl[11] = mk(2, 1, 0,  0,  0,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[12] = mk(2, 0, 1,  4,  2,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[13] = mk(2, 0, 1,  0,  1,   1,  0,   0,   0,   0,  1,  0,  0);
      tbl[14] = mk(2, 0, 1,  4,  2,   1,  0,   0,   0,   0,  2,  0,  0);
      tbl[15] = mk(2, 0, 1,  8,  3,   0,  1,   1,   0,   0,  3,  0,  0);
      tbl[16] = mk(2, 1, 1,  0,  1,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[17] = mk(2, 0, 0,  0,  1,   1,  0,   0,   0,   0,  0,  0,  0);
      tbl[18] = mk(2, 0, 1, 80,  9,   1,  0,   0,   0,   0,  0,  0,  0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("reset busy%0d", s), 64'(busy_v[s]), 64'd0);
         chk($sformatf("reset done%0d", s), 64'(done_v[s]), 64'd0);
         chk($sformatf("reset mc%0d", s), 64'(mc_v[s]), 64'd0);
         chk($sformatf("reset cc%0d", s), 64'(cc_v[s]), 64'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("idle after release busy", 64'(busy_v[0]), 64'd0);

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         start_v[tbl[i].sel] = tbl[i].st;
         memwrite  = tbl[i].mw;
         dataadr   = tbl[i].adr;
         writedata = tbl[i].dat;
         e.idx = i; e.sel = tbl[i].sel;
         e.busy = tbl[i].busy; e.done = tbl[i].done; e.pass = tbl[i].pass; e.fail = tbl[i].fail;
         e.code = tbl[i].code; e.mc = tbl[i].mc; e.ea = tbl[i].ea; e.ed = tbl[i].ed;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() > 0) cmp_exp(sb.pop_front());
         @(negedge clk);
         start_v[tbl[i].sel] = 1'b0;
         memwrite = 1'b0;
      end

      // Timeout with no stores
      pulse_start(2);
      repeat (15) @(posedge clk);
      #1;
      chk("to busy@15", 64'(busy_v[2]), 64'd1);
      chk("to cc@15", 64'(cc_v[2]), 64'd15);
      @(posedge clk);
      #1;
      chk("to fail", 64'(fail_v[2]), 64'd1);
      chk("to busy", 64'(busy_v[2]), 64'd0);
      chk("to code", 64'(code_v[2]), 64'd3);
      chk("to cc", 64'(cc_v[2]), 64'd16);
      chk("to err_addr", 64'(ea_v[2]), 64'd0);
      chk("to err_data", 64'(ed_v[2]), 64'd0);

      // Final matching store on the last budget edge beats the timeout
      pulse_start(0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
      @(posedge clk);
      #1;
      chk("edge16 pass", 64'(pass_v[0]), 64'd1);
      chk("edge16 code", 64'(code_v[0]), 64'd0);
      chk("edge16 cc", 64'(cc_v[0]), 64'd16);
      @(negedge clk);
      memwrite = 1'b0;
      @(posedge clk);
      #1;
      chk("cc frozen", 64'(cc_v[0]), 64'd16);

      // Async reset mid-RUN after one match
      pulse_start(2);
      store(32'd0, 32'd1);
      chk("pre-reset mc", 64'(mc_v[2]), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async busy", 64'(busy_v[2]), 64'd0);
      chk("async mc", 64'(mc_v[2]), 64'd0);
      chk("async cc", 64'(cc_v[2]), 64'd0);
      chk("async passA", 64'(pass_v[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post-release idle", 64'(busy_v[2]), 64'd0);
      pulse_start(2);
      store(32'd0, 32'd1);
      store(32'd4, 32'd2);
      store(32'd8, 32'd3);
      chk("rerun pass", 64'(pass_v[2]), 64'd1);
      chk("rerun mc", 64'(mc_v[2]), 64'd3);
      chk("rerun done", 64'(done_v[2]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
